uart_rx_ctrl: RTL

Frame-level controller of the UART receiver: a state machine plus edge and bit counters. It detects the start edge on RX_IN and times every bit of the frame in oversampling ticks. It drives the one-cycle enables for the data sampler, start checker, deserializer, parity checker and stop checker, and consumes their error flags. It issues DATA_VALID only for a fully error-free frame.

---
 rtl/uart_rx_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver frame controller (FSM, edge/bit counters, checker strobes)
// Optional build macro UART_RX_ERR_FLAGS_EN adds PAR_ERR_OUT / STP_ERR_OUT end-of-frame pulses.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  strt_glitch,
   input  logic                  par_err,
   input  logic                  stp_err,
   output logic                  dat_samp_en,
   output logic                  strt_chk_en,
   output logic                  deser_en,
   output logic                  par_chk_en,
   output logic                  stp_chk_en,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  DATA_VALID
`ifdef UART_RX_ERR_FLAGS_EN
   ,
   output logic                  PAR_ERR_OUT,
   output logic                  STP_ERR_OUT
`endif
);

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic                  par_en_q, par_en_d;
   logic                  err_q, err_d;
   logic                  dv_q, dv_d;
   logic                  bit_end;
   logic                  at_strobe;

   // Sampler majority output settles two ticks after mid-bit, hence P/2+2.
   assign bit_end   = (edge_q == presc_q - PRESCALE_W'(1));
   assign at_strobe = (edge_q == (presc_q >> 1) + PRESCALE_W'(2));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         edge_q   <= '0;
         bit_q    <= '0;
         presc_q  <= '0;
         par_en_q <= 1'b0;
         err_q    <= 1'b0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         edge_q   <= edge_d;
         bit_q    <= bit_d;
         presc_q  <= presc_d;
         par_en_q <= par_en_d;
         err_q    <= err_d;
         dv_q     <= dv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      edge_d   = bit_end ? '0 : edge_q + PRESCALE_W'(1);
      bit_d    = bit_q;
      presc_d  = presc_q;
      par_en_d = par_en_q;
      err_d    = err_q;
      dv_d     = 1'b0;
      case (state_q)
         IDLE: begin
            edge_d = '0;
            if (!RX_IN) begin
               // The detection cycle itself is tick 0 of the start bit.
               state_d  = START;
               edge_d   = PRESCALE_W'(1);
               presc_d  = Prescale;
               par_en_d = PAR_EN;
               err_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               if (strt_glitch) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  bit_d   = '0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               if (par_err) err_d = 1'b1;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               dv_d    = !err_q && !stp_err;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            edge_d  = '0;
            err_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      dat_samp_en = (state_q != IDLE);
      strt_chk_en = (state_q == START)  && at_strobe;
      deser_en    = (state_q == DATA)   && at_strobe;
      par_chk_en  = (state_q == PARITY) && at_strobe;
      stp_chk_en  = (state_q == STOP)   && at_strobe;
      edge_cnt    = edge_q;
      DATA_VALID  = dv_q;
   end

`ifdef UART_RX_ERR_FLAGS_EN
   logic pe_q, se_q;
   logic frame_end;

   assign frame_end = (state_q == STOP) && bit_end;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pe_q <= 1'b0;
         se_q <= 1'b0;
      end else begin
         pe_q <= frame_end && err_q;
         se_q <= frame_end && stp_err;
      end
   end

   assign PAR_ERR_OUT = pe_q;
   assign STP_ERR_OUT = se_q;
`endif

endmodule
